key_debounce_array: RTL

KEY_DEBOUNCE_ARRAY -- requirements
Module: key_debounce_array

---
 rtl/key_debounce_pkg.sv | 27 ++
 rtl/key_debounce_chan.sv | 73 +++++++
 rtl/key_debounce_array.sv | 104 ++++++++++
 3 files changed

// File: rtl/key_debounce_pkg.sv
// Shared constants and helpers for the key debounce array.
// Optional long-press detection is enabled by defining KEY_DEBOUNCE_LONGPRESS_EN.
package key_debounce_pkg;

    // Default build-time configuration
    localparam int DEF_N_CH   = 8;
    localparam int DEF_CNT_W  = 22;
    localparam int DEF_HOLD_W = 4;

    // Debounced edge event produced by a channel on a level update
    typedef enum logic [1:0] {
        EVT_NONE    = 2'd0,
        EVT_PRESS   = 2'd1,
        EVT_RELEASE = 2'd2
    } key_evt_e;

    // Width needed to hold a channel index, never less than one bit
    function automatic int code_width(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/key_debounce_chan.sv
// One debounced key channel: two-flop synchroniser, stability counter,
// registered debounced level and one-cycle press/release pulses.
// Used by key_debounce_array; KEY_DEBOUNCE_LONGPRESS_EN does not affect it.
module key_debounce_chan
    import key_debounce_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic CLK,
    input  logic RESET,
    input  logic key_in,
    output logic key_level,
    output logic key_press,
    output logic key_release
);

    localparam logic [CNT_W-1:0] TERM = '1;

    logic             s1;
    logic             s2;
    logic [CNT_W-1:0] count;
    logic             inc;
    logic             update;
    key_evt_e         evt;

    // Bring the asynchronous key level into the clock domain
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= key_in;
            s2 <= s1;
        end
    end

    // Decide whether the synchronised level is a stable candidate for a new level
    always_comb begin
        inc    = (s1 == s2) && (s2 != key_level);
        update = inc && (count == TERM);
        evt    = EVT_NONE;
        if (update) begin
            evt = s2 ? EVT_PRESS : EVT_RELEASE;
        end
    end

    // Count stable samples; adopt the new level once the threshold is met
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            count     <= '0;
            key_level <= 1'b0;
        end else if (!inc) begin
            count     <= '0;
        end else if (update) begin
            count     <= '0;
            key_level <= s2;
        end else begin
            count     <= count + 1'b1;
        end
    end

    // Pulses line up with the cycle the debounced level first changes
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            key_press   <= 1'b0;
            key_release <= 1'b0;
        end else begin
            key_press   <= (evt == EVT_PRESS);
            key_release <= (evt == EVT_RELEASE);
        end
    end

endmodule

// File: rtl/key_debounce_array.sv
// Array of debounced key channels with a lowest-index priority encoder.
// Defining KEY_DEBOUNCE_LONGPRESS_EN adds a shared prescaler and per-channel
// hold counters that drive KEY_LONG; otherwise KEY_LONG is tied low.
module key_debounce_array
    import key_debounce_pkg::*;
#(
    parameter int N_CH   = DEF_N_CH,
    parameter int CNT_W  = DEF_CNT_W,
    parameter int HOLD_W = DEF_HOLD_W
) (
    input  logic                        CLK,
    input  logic                        RESET,
    input  logic [N_CH-1:0]             KEY_IN,
    output logic [N_CH-1:0]             KEY_LEVEL,
    output logic [N_CH-1:0]             KEY_PRESS,
    output logic [N_CH-1:0]             KEY_RELEASE,
    output logic [N_CH-1:0]             KEY_LONG,
    output logic [code_width(N_CH)-1:0] KEY_CODE,
    output logic                        KEY_VALID
);

    localparam int CODE_W = code_width(N_CH);

    // Reject configurations outside the supported range at elaboration
    if (N_CH < 1 || N_CH > 32 || CNT_W < 1 || HOLD_W < 1) begin : g_param_check
        $error("key_debounce_array: unsupported parameter set");
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_chan
        key_debounce_chan #(
            .CNT_W(CNT_W)
        ) u_chan (
            .CLK         (CLK),
            .RESET       (RESET),
            .key_in      (KEY_IN[i]),
            .key_level   (KEY_LEVEL[i]),
            .key_press   (KEY_PRESS[i]),
            .key_release (KEY_RELEASE[i])
        );
    end

    // Lowest-numbered active channel wins; scanning downward lets it overwrite
    always_comb begin
        KEY_CODE  = '0;
        KEY_VALID = |KEY_LEVEL;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (KEY_LEVEL[i]) begin
                KEY_CODE = CODE_W'(i);
            end
        end
    end

`ifdef KEY_DEBOUNCE_LONGPRESS_EN

    localparam logic [CNT_W-1:0]  PRE_TERM  = '1;
    localparam logic [HOLD_W-1:0] HOLD_TERM = '1;

    logic [CNT_W-1:0]  prescale;
    logic              tick;
    logic [HOLD_W-1:0] hold [N_CH];
    logic [N_CH-1:0]   long_q;

    // Free-running prescaler shared by every channel
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            prescale <= '0;
        end else begin
            prescale <= prescale + 1'b1;
        end
    end

    // One tick per full prescaler period
    always_comb begin
        tick = (prescale == PRE_TERM);
    end

    // Hold counters advance on ticks while pressed and saturate at the long-press mark
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            for (int i = 0; i < N_CH; i++) begin
                hold[i]   <= '0;
                long_q[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                long_q[i] <= KEY_LEVEL[i] && tick && (hold[i] == HOLD_TERM - 1'b1);
                if (!KEY_LEVEL[i]) begin
                    hold[i] <= '0;
                end else if (tick && (hold[i] != HOLD_TERM)) begin
                    hold[i] <= hold[i] + 1'b1;
                end
            end
        end
    end

    assign KEY_LONG = long_q;

`else

    assign KEY_LONG = '0;

`endif

endmodule
